// File: rtl/alu_tmr_pkg.sv
// Shared definitions for the triple-issue ALU sequencer: FSM states, flag bit
// positions, opcode constants and the packed result/flag slot layout.
package alu_tmr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_VOTE   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  localparam int DATA_W  = 32;
  localparam int FLAGS_W = 4;
  localparam int SLOT_W  = DATA_W + FLAGS_W;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
  } slot_t;

  function automatic slot_t pack_slot(input logic [DATA_W-1:0] result,
                                      input logic [FLAGS_W-1:0] flags);
    slot_t s;
    s.result = result;
    s.flags  = flags;
    return s;
  endfunction

endpackage

// File: rtl/tmr_voter3.sv
// Combinational bitwise 2-of-3 majority voter with disagreement (err) and
// no-pair-agrees (fatal) detection.
module tmr_voter3 #(
  parameter int W = 36
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_maj,
  output logic         o_err,
  output logic         o_fatal
);

  logic w_ab_eq;
  logic w_bc_eq;
  logic w_ac_eq;

  // Pairwise equality feeds both the err and fatal decisions.
  always_comb begin
    w_ab_eq = (i_a == i_b);
    w_bc_eq = (i_b == i_c);
    w_ac_eq = (i_a == i_c);
    o_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    o_err   = !(w_ab_eq && w_bc_eq);
    o_fatal = !w_ab_eq && !w_bc_eq && !w_ac_eq;
  end

endmodule

// File: rtl/alu_tmr_sequencer.sv
// Triple-issue ALU sequencer: runs each accepted operation three times on an
// external combinational ALU and returns the registered 2-of-3 vote.
module alu_tmr_sequencer
  import alu_tmr_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [2:0]           in_ctrl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [3:0]           out_flags,
  output logic                 out_err,
  output logic                 out_fatal,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_do_vote;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [31:0]         r_op_a;
  logic [31:0]         r_op_b;
  logic [2:0]          r_op_ctrl;

  slot_t               r_slot0;
  slot_t               r_slot1;
  slot_t               r_slot2;
  slot_t               w_capture;

  slot_t               w_vote;
  logic                w_vote_err;
  logic                w_vote_fatal;

  logic [31:0]         r_out_result;
  logic [3:0]          r_out_flags;
  logic                r_out_err;
  logic                r_out_fatal;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Next-state decode; acceptance only from IDLE, so retirement never overlaps an accept.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_do_vote   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_ISSUE0;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE0: w_state_nxt = ST_ISSUE1;
      ST_ISSUE1: w_state_nxt = ST_ISSUE2;
      ST_ISSUE2: w_state_nxt = ST_VOTE;
      ST_VOTE: begin
        w_state_nxt = ST_RESP;
        w_do_vote   = 1'b1;
      end
      ST_RESP: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // Operand capture; the requester may change its inputs freely afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_a    <= 32'h0000_0000;
      r_op_b    <= 32'h0000_0000;
      r_op_ctrl <= 3'b000;
    end else if (w_accept) begin
      r_op_a    <= in_a;
      r_op_b    <= in_b;
      r_op_ctrl <= in_ctrl;
    end else begin
      r_op_a    <= r_op_a;
      r_op_b    <= r_op_b;
      r_op_ctrl <= r_op_ctrl;
    end
  end

  assign w_capture = pack_slot(alu_result, alu_flags);

  // One slot per issue cycle; the ALU sees identical operands in all three.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else begin
      case (r_state)
        ST_ISSUE0: r_slot0 <= w_capture;
        ST_ISSUE1: r_slot1 <= w_capture;
        ST_ISSUE2: r_slot2 <= w_capture;
        default: begin
          r_slot0 <= r_slot0;
          r_slot1 <= r_slot1;
          r_slot2 <= r_slot2;
        end
      endcase
    end
  end

  tmr_voter3 #(
    .W (SLOT_W)
  ) u_voter (
    .i_a     (r_slot0),
    .i_b     (r_slot1),
    .i_c     (r_slot2),
    .o_maj   (w_vote),
    .o_err   (w_vote_err),
    .o_fatal (w_vote_fatal)
  );

  // Response registers change only at the VOTE edge and hold through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_result <= 32'h0000_0000;
      r_out_flags  <= 4'b0000;
      r_out_err    <= 1'b0;
      r_out_fatal  <= 1'b0;
    end else if (w_do_vote) begin
      r_out_result <= w_vote.result;
      r_out_flags  <= w_vote.flags;
      r_out_err    <= w_vote_err;
      r_out_fatal  <= w_vote_fatal;
    end else begin
      r_out_result <= r_out_result;
      r_out_flags  <= r_out_flags;
      r_out_err    <= r_out_err;
      r_out_fatal  <= r_out_fatal;
    end
  end

  // Saturating disagreement counter; a clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= {ERR_CNT_W{1'b0}};
    end else if (err_clr) begin
      r_err_count <= {ERR_CNT_W{1'b0}};
    end else if (w_do_vote && w_vote_err && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + CNT_ONE;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_a      = r_op_a;
  assign alu_b      = r_op_b;
  assign alu_ctrl   = r_op_ctrl;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign out_err    = r_out_err;
  assign out_fatal  = r_out_fatal;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_tmr_sequencer.sv
// Self-checking bench: fault-injecting ALU model, directed vector table,
// hand-written corner sequences and randomized ops checked against a vote model.
module tb_alu_tmr_sequencer;
  import alu_tmr_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic        out_fatal;
  logic [7:0]  err_count;
  logic        err_clr;
  logic [35:0] fault_mask;

  int          n_pass;
  int          n_total;
  logic [7:0]  exp_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [35:0] m0;
    logic [35:0] m1;
    logic [35:0] m2;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
    logic        fatal;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  alu_tmr_sequencer #(.ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ctrl    (in_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .out_fatal  (out_fatal),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {result, N, Z, C, V}; C on subtraction means borrow.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [32:0] wide;
    logic [31:0] r;
    logic [3:0]  f;
    wide = 33'h0;
    r    = 32'h0;
    f    = 4'b0000;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        r         = wide[31:0];
        f[FLAG_C] = wide[32];
        f[FLAG_V] = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r         = a - b;
        f[FLAG_C] = (a < b);
        f[FLAG_V] = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    f[FLAG_N] = r[31];
    f[FLAG_Z] = (r == 32'h0);
    return {r, f};
  endfunction

  assign {alu_result, alu_flags} = alu_ref(alu_a, alu_b, alu_ctrl) ^ fault_mask;

  // Expected vote {fatal, err, value}: per-bit counting and distinct-value count.
  function automatic logic [37:0] vote_ref(input logic [35:0] s0, input logic [35:0] s1,
                                           input logic [35:0] s2);
    logic [35:0] v;
    int          ones;
    int          distinct;
    for (int i = 0; i < 36; i++) begin
      ones = 0;
      if (s0[i]) ones++;
      if (s1[i]) ones++;
      if (s2[i]) ones++;
      v[i] = (ones >= 2);
    end
    distinct = 1;
    if (s1 != s0) distinct++;
    if (s2 != s0 && s2 != s1) distinct++;
    return {(distinct == 3), (distinct > 1), v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for in_ready, present v, end just after the accepting edge.
  task automatic accept_op(input vec_t v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_wait", 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_ctrl  = v.op;
    @(posedge clk); #1;
    chk("accepted", 64'(in_ready), 64'(1'b0));
    in_valid = 1'($urandom_range(0, 1));
    in_a     = $urandom;
    in_b     = $urandom;
    in_ctrl  = 3'($urandom);
  endtask

  // Drive the three issue cycles, check the vote, hold for `hold` cycles, retire.
  task automatic complete_op(input vec_t v, input int hold, input bit clr_at_vote,
                             input bit chain, input vec_t nv);
    for (int k = 0; k < 3; k++) begin
      fault_mask = (k == 0) ? v.m0 : ((k == 1) ? v.m1 : v.m2);
      chk("alu_a_stable", 64'(alu_a), 64'(v.a));
      chk("alu_b_stable", 64'(alu_b), 64'(v.b));
      chk("alu_ctrl_pass", 64'(alu_ctrl), 64'(v.op));
      chk("no_early_valid", 64'(out_valid), 64'(1'b0));
      @(posedge clk); #1;
    end
    fault_mask = 36'h0;
    chk("vote_no_valid", 64'(out_valid), 64'(1'b0));
    err_clr = clr_at_vote;
    @(posedge clk); #1;
    err_clr = 1'b0;
    if (clr_at_vote) exp_cnt = 8'd0;
    else if (v.err && exp_cnt < 8'd255) exp_cnt = exp_cnt + 8'd1;
    chk("valid_latency", 64'(out_valid), 64'(1'b1));
    chk("resp_not_ready", 64'(in_ready), 64'(1'b0));
    chk("result", 64'(out_result), 64'(v.res));
    chk("flags", 64'(out_flags), 64'(v.flg));
    chk("err", 64'(out_err), 64'(v.err));
    chk("fatal", 64'(out_fatal), 64'(v.fatal));
    chk("err_count", 64'(err_count), 64'(exp_cnt));
    out_ready = 1'b0;
    if (chain) begin
      in_valid = 1'b1;
      in_a     = nv.a;
      in_b     = nv.b;
      in_ctrl  = nv.op;
    end else begin
      in_valid = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1'b1));
      chk("hold_no_accept", 64'(in_ready), 64'(1'b0));
      chk("hold_result", 64'(out_result), 64'(v.res));
      chk("hold_flags", 64'(out_flags), 64'(v.flg));
      chk("hold_err", 64'(out_err), 64'(v.err));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retired_valid", 64'(out_valid), 64'(1'b0));
    chk("retired_ready", 64'(in_ready), 64'(1'b1));
    if (chain) begin
      @(posedge clk); #1;
      chk("chain_accept", 64'(in_ready), 64'(1'b0));
      chk("chain_alu_a", 64'(alu_a), 64'(nv.a));
      chk("chain_alu_b", 64'(alu_b), 64'(nv.b));
      in_valid = 1'b0;
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t        v;
    logic [63:0] t;
    logic [35:0] gold;
    logic [37:0] e;
    logic [2:0]  ops [6];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND;
    ops[3] = OP_OR;  ops[4] = OP_SLT; ops[5] = 3'($urandom);
    v.a  = $urandom;
    v.b  = $urandom;
    v.op = ops[$urandom_range(0, 5)];
    t = {$urandom, $urandom}; v.m0 = ($urandom_range(0, 3) == 0) ? t[35:0] : 36'h0;
    t = {$urandom, $urandom}; v.m1 = ($urandom_range(0, 3) == 0) ? t[35:0] : 36'h0;
    t = {$urandom, $urandom}; v.m2 = ($urandom_range(0, 3) == 0) ? t[35:0] : 36'h0;
    gold    = alu_ref(v.a, v.b, v.op);
    e       = vote_ref(gold ^ v.m0, gold ^ v.m1, gold ^ v.m2);
    v.res   = e[35:4];
    v.flg   = e[3:0];
    v.err   = e[36];
    v.fatal = e[37];
    return v;
  endfunction

  initial begin
    vec_t rv;
    n_pass = 0; n_total = 0; exp_cnt = 8'd0;
    rst = 1'b0; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_ctrl = 3'b000;
    out_ready = 1'b0; err_clr = 1'b0; fault_mask = 36'h0;

    //         a             b             op      m0              m1              m2      res           flg    err   fatal
    tbl[0] = '{32'd5,        32'd7,        OP_ADD, 36'h0,          36'h0,          36'h0,  32'd12,       4'h0, 1'b0, 1'b0};
    tbl[1] = '{32'd10,       32'd10,       OP_SUB, 36'h0,          36'h0_0000_0010, 36'h0, 32'd0,        4'h4, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF0000, 32'h0F0F0F0F, OP_AND, 36'h8_0000_0000, 36'h0_0000_0010, 36'h0, 32'h0F0F0000, 4'h0, 1'b1, 1'b1};
    tbl[3] = '{32'h12340000, 32'h00005678, OP_OR,  36'h0,          36'h0,          36'h1,  32'h12345678, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'd1,        OP_SLT, 36'h0,          36'h0,          36'h0,  32'd1,        4'h0, 1'b0, 1'b0};
    tbl[5] = '{32'hAAAA5555, 32'h5555AAAA, 3'b111, 36'h0,          36'h0,          36'h0,  32'd0,        4'h4, 1'b0, 1'b0};
    tbl[6] = '{32'h7FFFFFFF, 32'd1,        OP_ADD, 36'h0,          36'h0,          36'h0,  32'h80000000, 4'h9, 1'b0, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 32'd1,        OP_ADD, 36'h0,          36'h0,          36'h0,  32'd0,        4'h6, 1'b0, 1'b0};
    tbl[8] = '{32'd3,        32'd5,        OP_SUB, 36'h0,          36'h0,          36'h0,  32'hFFFFFFFE, 4'hA, 1'b0, 1'b0};
    tbl[9] = '{32'd1,        32'hFFFFFFFF, OP_SLT, 36'h1,          36'h2,          36'h4,  32'd0,        4'h4, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_result", 64'(out_result), 64'h0);
    chk("rst_flags", 64'(out_flags), 64'h0);
    chk("rst_err", 64'(out_err), 64'h0);
    chk("rst_fatal", 64'(out_fatal), 64'h0);
    chk("rst_err_count", 64'(err_count), 64'h0);
    chk("rst_alu_a", 64'(alu_a), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      accept_op(tbl[i]);
      complete_op(tbl[i], i % 3, 1'b0, 1'b0, tbl[i]);
    end

    // Backpressure with a waiting requester, then accept right after retirement.
    accept_op(tbl[0]);
    complete_op(tbl[0], 3, 1'b0, 1'b1, tbl[8]);
    complete_op(tbl[8], 0, 1'b0, 1'b0, tbl[8]);

    // Reset during ISSUE1 aborts the operation.
    accept_op(tbl[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    exp_cnt = 8'd0;
    chk("abort_valid", 64'(out_valid), 64'(1'b0));
    chk("abort_ready", 64'(in_ready), 64'(1'b1));
    chk("abort_err_count", 64'(err_count), 64'h0);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid), 64'(1'b0));
    end

    for (int i = 0; i < 40; i++) begin
      rv = rand_vec();
      accept_op(rv);
      complete_op(rv, $urandom_range(0, 2), 1'b0, 1'b0, rv);
    end

    // Drive the counter to saturation, one more faulty op, then clear at VOTE.
    while (exp_cnt < 8'd255) begin
      accept_op(tbl[1]);
      complete_op(tbl[1], 0, 1'b0, 1'b0, tbl[1]);
    end
    accept_op(tbl[3]);
    complete_op(tbl[3], 0, 1'b0, 1'b0, tbl[3]);
    accept_op(tbl[2]);
    complete_op(tbl[2], 0, 1'b1, 1'b0, tbl[2]);
    accept_op(tbl[0]);
    complete_op(tbl[0], 0, 1'b0, 1'b0, tbl[0]);
    accept_op(tbl[1]);
    complete_op(tbl[1], 1, 1'b0, 1'b0, tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_tmr_sequencer.md
ALU_TMR_SEQUENCER -- requirements
Module: alu_tmr_sequencer

Interface
REQ-001 Parameter: ERR_CNT_W, 8, width of the saturating mismatch counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block accepts an operation; high only in IDLE.
REQ-006 in_a / in_b  input  32  operands.
REQ-007 in_ctrl  input  3  ALU operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 alu_a / alu_b  output  32  operands driven to the external ALU.
REQ-009 alu_ctrl  output  3  operation code driven to the external ALU.
REQ-010 alu_result  input  32  external ALU result, combinational on alu_a/alu_b/alu_ctrl.
REQ-011 alu_flags  input  4  external ALU flags {N,Z,C,V}.
REQ-012 out_valid  output  1  voted response available.
REQ-013 out_ready  input  1  consumer takes the response.
REQ-014 out_result  output  32  voted result.
REQ-015 out_flags  output  4  voted flags {N,Z,C,V}.
REQ-016 out_err  output  1  at least one of the three runs disagreed.
REQ-017 out_fatal  output  1  no two runs agreed; result untrustworthy.
REQ-018 err_count  output  ERR_CNT_W  saturating count of responses with out_err=1.
REQ-019 err_clr  input  1  synchronous clear of err_count.

Function
REQ-020 FSM states: IDLE, ISSUE0, ISSUE1, ISSUE2, VOTE, RESP.
REQ-021 IDLE: in_valid=1 -> latch in_a/in_b/in_ctrl into operand registers, go to ISSUE0.
REQ-022 alu_a/alu_b/alu_ctrl are driven from the operand registers in every state; they stay stable across ISSUE0-ISSUE2.
REQ-023 ISSUEk (k=0,1,2): capture {alu_result, alu_flags} into slot k at end of cycle; advance to ISSUE(k+1) or, from ISSUE2, to VOTE.
REQ-024 VOTE: register bitwise 2-of-3 majority of the three 36-bit slots into out_result/out_flags, and out_err/out_fatal; go to RESP.
REQ-025 out_err=1 when the three 36-bit slots are not all equal; out_fatal=1 when no pair of slots is equal.
REQ-026 RESP: out_valid=1; outputs held constant until out_valid and out_ready both high, then go to IDLE.
REQ-027 in_ready is low in RESP; no same-cycle accept on response retirement.
REQ-028 Latency: out_valid rises after exactly 4 rising edges following the accepting edge; minimum 6 cycles per operation.
REQ-029 in_valid/operand changes after acceptance have no effect.
REQ-030 err_count increments by 1 at the VOTE edge when out_err is computed as 1; holds at 2^ERR_CNT_W-1.
REQ-031 err_clr=1 forces err_count to 0 on the next edge; err_clr takes priority over a simultaneous increment.
REQ-032 Undefined in_ctrl codes are passed through unchanged; the block does not interpret opcodes.

Reset
REQ-033 rst low: state IDLE; operand registers, slots, out_result, out_flags, out_err, out_fatal, err_count all 0; out_valid=0; in_ready=1.
REQ-034 Reset asserted mid-operation aborts it; no out_valid for the aborted operation is ever produced.

Structure
REQ-035 Shared package alu_tmr_pkg: FSM state enum, flag bit indices (N=3,Z=2,C=1,V=0), ALU opcode constants.
REQ-036 One sub-module, tmr_voter3: parameterised width, combinational bitwise majority plus err/fatal detection; instantiated once at 36 bits.

Verification
REQ-037 Fault-free ALU model, add 5+7 -> out_result=12, out_flags=0000, out_err=0, out_fatal=0, out_valid exactly 4 edges after accept.
REQ-038 sub 10-10, alu_result bit0 flipped during ISSUE1 only -> out_result=0, Z=1, out_err=1, out_fatal=0, err_count=1.
REQ-039 and 0xFFFF0000 & 0x0F0F0F0F, slot0 and slot1 corrupted differently -> out_fatal=1, out_err=1.
REQ-040 out_ready low 3 cycles in RESP with in_valid=1 -> outputs stable, in_ready=0, no new accept; retire, then accept next cycle.
REQ-041 rst pulsed low during ISSUE1 -> out_valid stays 0, in_ready=1, err_count=0.
REQ-042 err_count at 255 plus faulty op -> stays 255; err_clr together with a faulty VOTE -> err_count=0.
